// File: rtl/instr_mem_pkg.sv
// Shared boot-ROM constants and loader state type for the instruction memory path.
package instr_mem_pkg;

  localparam logic [31:0] BOOT_BASE_ADDR = 32'hBFC00000;
  localparam int unsigned IMEM_BYTES     = 4096;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// Packs stream bytes MSB-first into a word; partial words are left-aligned with zero fill.
module word_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  strobe_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  input  logic                  last_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  word_ready_o,
  output logic                  empty_o
);

  localparam int unsigned BYTES = WORD_WIDTH / DATA_WIDTH;
  localparam int unsigned CW    = $clog2(BYTES) + 1;

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (strobe_i) begin
      shreg_d = {shreg_q[WORD_WIDTH-DATA_WIDTH-1:0], byte_i};
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // word_o reflects the contents after this cycle's byte, so the FSM can latch it on the closing handshake
  always_comb begin
    word_o = shreg_d;
    for (int unsigned i = 1; i < BYTES; i++) begin
      if (cnt_d == CW'(i)) word_o = shreg_d << (DATA_WIDTH * (BYTES - i));
    end
  end

  assign word_ready_o = strobe_i & ((cnt_q == CW'(BYTES - 1)) | last_i);
  assign empty_o      = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-ROM writer: streams bytes into word writes from BASE_ADDR and stalls the CPU until done.
// Optional running sum of written words when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 8,
  parameter int unsigned              WORD_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = ADDRESS_WIDTH'(BOOT_BASE_ADDR),
  parameter int unsigned              MEM_BYTES     = IMEM_BYTES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic                            we,
  output logic [ADDRESS_WIDTH-1:0]        WA,
  output logic [WORD_WIDTH-1:0]           WD,
  output logic                            busy,
  output logic                            done,
  output logic                            err_overflow,
  output logic                            cpu_stall,
  output logic [$clog2(MEM_BYTES/4):0]    word_count,
  output logic [WORD_WIDTH-1:0]           checksum
);

  localparam int unsigned WCW = $clog2(MEM_BYTES / 4) + 1;
  localparam logic [ADDRESS_WIDTH-1:0] STEP       = ADDRESS_WIDTH'(WORD_WIDTH / DATA_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] LIMIT_ADDR = BASE_ADDR + ADDRESS_WIDTH'(MEM_BYTES);

  loader_state_t          state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [WCW-1:0]         wc_q, wc_d;
  logic                   last_q, last_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
  logic [WORD_WIDTH-1:0]  wd_q, wd_d;
  logic                   we_q, busy_q, done_q, err_q, stall_q;

  logic                   pk_clear, pk_empty, pk_word_ready, hs, at_limit, start_ok;
  logic [WORD_WIDTH-1:0]  pk_word;

  assign start_ok = start & (state_q inside {IDLE, DONE, ERR});
  // Memory full is only detected once the previous word is out, so a refused byte never splits a word
  assign at_limit = pk_empty & (addr_q == LIMIT_ADDR);
  assign in_ready = (state_q == COLLECT) & ~at_limit;
  assign hs       = in_valid & in_ready;
  assign pk_clear = start_ok | (state_q == WRITE);

  word_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (pk_clear),
    .strobe_i    (hs),
    .byte_i      (in_data),
    .last_i      (in_last),
    .word_o      (pk_word),
    .word_ready_o(pk_word_ready),
    .empty_o     (pk_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    last_d  = last_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = COLLECT;
          addr_d  = BASE_ADDR;
          wc_d    = '0;
        end
      end
      COLLECT: begin
        if (at_limit && in_valid) begin
          state_d = ERR;
        end else if (pk_word_ready) begin
          state_d = WRITE;
          wa_d    = addr_q;
          wd_d    = pk_word;
          last_d  = in_last;
        end
      end
      WRITE: begin
        addr_d  = addr_q + STEP;
        wc_d    = wc_q + WCW'(1);
        state_d = last_q ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      wc_q    <= '0;
      last_q  <= 1'b0;
      wa_q    <= BASE_ADDR;
      wd_q    <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      last_q  <= last_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= (state_d == WRITE);
      busy_q  <= (state_d == COLLECT) | (state_d == WRITE);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERR);
      stall_q <= (state_d != DONE);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) sum_q <= '0;
    else if (state_q == WRITE) sum_q <= sum_q + wd_q;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign we           = we_q;
  assign WA           = wa_q;
  assign WD           = wd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign cpu_stall    = stall_q;
  assign word_count   = wc_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a byte-list model of the expected word writes.
module tb_instr_mem_loader;

  localparam int unsigned MEMB = 16;
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk, rst, start, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, we, busy, done, err_overflow, cpu_stall;
  logic [31:0] WA, WD, checksum;
  logic [$clog2(MEMB/4):0] word_count;

  instr_mem_loader #(.MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .we(we), .WA(WA), .WD(WD), .busy(busy),
    .done(done), .err_overflow(err_overflow), .cpu_stall(cpu_stall),
    .word_count(word_count), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0, failures = 0, cyc = 0;
  bit          cmp_en = 1'b0;
  logic [7:0]  img[$];
  logic [31:0] exp_wa[$], exp_wd[$];
  logic [31:0] exp_sum;
  int          exp_words;
  int          we_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Expected writes: bytes grouped by four, first byte in the top lane, short tail zero-filled
  task automatic build_expect(input int n_take);
    logic [31:0] w;
    exp_wa.delete();
    exp_wd.delete();
    exp_sum   = '0;
    exp_words = (n_take + 3) / 4;
    for (int k = 0; k < exp_words; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n_take) w = w | (32'(img[4 * k + j]) << (24 - 8 * j));
      exp_wa.push_back(BASE + 32'(4 * k));
      exp_wd.push_back(w);
      exp_sum = exp_sum + w;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      if (we === 1'b1) begin
        we_cyc.push_back(cyc);
        if (exp_wa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=WA %h WD %h required=no write", WA, WD);
        end else begin
          chk("write_addr", WA, exp_wa.pop_front());
          chk("write_data", WD, exp_wd.pop_front());
          chk1("in_ready_in_write", in_ready, 1'b0);
        end
      end
      chk1("stall_only_low_in_done", cpu_stall, ~done);
`ifndef LOADER_CHECKSUM_EN
      chk("checksum_tied_zero", checksum, 32'h0);
`endif
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_image(input int unsigned gap, input bit with_last, input int max_bytes,
                            output int accepted);
    int idx = 0;
    int guard = 0;
    accepted = 0;
    while (idx < img.size() && idx < max_bytes) begin
      @(negedge clk);
      if (err_overflow) break;
      if (++guard > 2000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=%0d bytes required=%0d bytes", idx, img.size());
        break;
      end
      in_valid = ($urandom_range(99) >= gap);
      in_data  = img[idx];
      in_last  = with_last && (idx == img.size() - 1);
      if (in_valid && in_ready) begin
        idx++;
        accepted++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 60; i++) begin
      if (done || err_overflow) break;
      @(negedge clk);
    end
    if (!(done || err_overflow)) begin
      checks++;
      failures++;
      $display("FAIL wait_end_timeout actual=busy required=done or err");
    end
  endtask

  task automatic check_done(input int accepted);
    chk1("done", done, 1'b1);
    chk1("cpu_stall", cpu_stall, 1'b0);
    chk1("busy_in_done", busy, 1'b0);
    chk1("err_in_done", err_overflow, 1'b0);
    chk1("in_ready_in_done", in_ready, 1'b0);
    chk("word_count", 32'(word_count), 32'(exp_words));
    chk("pending_writes", 32'(exp_wa.size()), 32'h0);
    chk("bytes_accepted", 32'(accepted), 32'(img.size()));
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", checksum, exp_sum);
`endif
  endtask

  task automatic load(input int unsigned gap, output int accepted);
    we_cyc.delete();
    build_expect(img.size());
    do_start();
    send_image(gap, 1'b1, 1000, accepted);
    wait_end();
    check_done(accepted);
  endtask

  initial begin
    int acc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_we", we, 1'b0);
    chk("rst_WA", WA, BASE);
    chk("rst_WD", WD, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err_overflow, 1'b0);
    chk1("rst_stall", cpu_stall, 1'b1);
    chk("rst_word_count", 32'(word_count), 32'h0);
    chk("rst_checksum", checksum, 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Two full words at full rate
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    build_expect(img.size());
    chk("model_w0", exp_wd[0], 32'h11223344);
    chk("model_w1", exp_wd[1], 32'h55667788);
    load(0, acc);
    chk("word_count_two", 32'(word_count), 32'd2);
    chk("we_pulses", 32'(we_cyc.size()), 32'd2);
    if (we_cyc.size() == 2) chk("word_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd5);

    // Partial tail word
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    build_expect(img.size());
    chk("model_tail_addr", exp_wa[1], 32'hBFC00004);
    chk("model_tail_data", exp_wd[1], 32'hEE000000);
    load(15, acc);

    // Words 00000001 + FFFFFFFF wrap to zero
    img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load(0, acc);
    chk("checksum_wrap", checksum, 32'h0);

    // Random images with random gaps
    for (int t = 0; t < 15; t++) begin
      int n = int'($urandom_range(MEMB, 1));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      load($urandom_range(60), acc);
    end

    // Overflow: 20 bytes without last into 16 bytes of memory
    img.delete();
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
    build_expect(MEMB);
    do_start();
    send_image(30, 1'b0, 1000, acc);
    wait_end();
    chk("ovf_accepted", 32'(acc), 32'd16);
    chk1("ovf_err", err_overflow, 1'b1);
    chk1("ovf_stall", cpu_stall, 1'b1);
    chk1("ovf_done", done, 1'b0);
    chk1("ovf_busy", busy, 1'b0);
    chk1("ovf_in_ready", in_ready, 1'b0);
    chk("ovf_word_count", 32'(word_count), 32'd4);
    chk("ovf_pending", 32'(exp_wa.size()), 32'h0);
    repeat (3) @(negedge clk);
    chk1("ovf_err_sticky", err_overflow, 1'b1);

    // Restart from ERR clears the error and begins again at BASE
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_expect(img.size());
    do_start();
    chk1("restart_err_clear", err_overflow, 1'b0);
    chk1("restart_busy", busy, 1'b1);
    chk1("restart_in_ready", in_ready, 1'b1);
    chk("restart_word_count", 32'(word_count), 32'h0);
    send_image(20, 1'b1, 1000, acc);
    wait_end();
    check_done(acc);

    // Reset after two bytes of the first word: no write may follow
    img = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95};
    build_expect(img.size());
    do_start();
    send_image(0, 1'b1, 2, acc);
    rst = 1'b1;
    exp_wa.delete();
    exp_wd.delete();
    @(negedge clk);
    rst = 1'b0;
    chk1("midrst_we", we, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_stall", cpu_stall, 1'b1);
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_word_count", 32'(word_count), 32'h0);
    chk("midrst_WA", WA, BASE);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("midrst_no_write", we, 1'b0);
    end

    // Clean load after the aborted one
    img.delete();
    for (int i = 0; i < 11; i++) img.push_back(8'($urandom));
    load(40, acc);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
